pe_job_scheduler: RTL
=====================

PE_JOB_SCHEDULER -- requirements
Module: pe_job_scheduler

Interface
REQ-001 SHALL have parameters: DATA_WIDTH=20 (PE data width); STRIDE_WIDTH=2; FILTER_SIZE_WIDTH=4; IFMAP_MEM_AW=6 (IFMap source address width); FILTER_MEM_AW=5 (filter source address width).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-low reset.
- job_valid / job_ready  in / out  1 / 1  job descriptor handshake.
- job_ifmap_base / job_ifmap_len  in  IFMAP_MEM_AW each  first IFMap word address / IFMap word count.
- job_filter_base / job_filter_len  in  FILTER_MEM_AW each  first filter word address / filter word count.
- job_stride, job_filter_size, job_mode, job_wr_psum  in  STRIDE_WIDTH, FILTER_SIZE_WIDTH, 2, 1  PE configuration.
- ifmap_ren / ifmap_raddr  out  1 / IFMAP_MEM_AW  IFMap source read request and address.
- ifmap_rdata  in  DATA_WIDTH+2  tagged IFMap word, valid 1 cycle after ifmap_ren.
- filter_ren / filter_raddr  out  1 / FILTER_MEM_AW  filter source read request and address.
- filter_rdata  in  DATA_WIDTH  filter word, valid 1 cycle after filter_ren.
- wen_IFMap / IFMap_din  out  1 / DATA_WIDTH+2  IFMap FIFO write.
- ready_IFMap  in  1  IFMap FIFO not full.
- wen_Filter / Filter_din  out  1 / DATA_WIDTH  filter FIFO write.
- ready_Filter  in  1  filter FIFO not full.
- Start  out  1  PE start pulse.
- stride, filter_size, mode, wr_psum  out  per job fields  PE configuration.
- pe_ready / pe_done  in  1 / 1  PE idle / PE job-complete pulse.
- busy / job_done  out  1 / 1  job in progress / 1-cycle completion pulse.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD_FILTER, LOAD_IFMAP, START, RUN.
REQ-004 SHALL assert job_ready only in IDLE; accepting a job (job_valid & job_ready) at cycle T SHALL latch all job fields and configuration outputs, which SHALL then stay constant until the next accept.
REQ-005 SHALL go from IDLE to LOAD_FILTER at T+1; a phase with len 0 SHALL be skipped in zero cycles (filter skipped -> LOAD_IFMAP; both skipped -> START).
REQ-006 SHALL transfer each word in two sub-cycles:
- READ: ren=1, address = base+index, issued only when the phase FIFO's ready=1; otherwise wait.
- WRITE: wen=1, din = rdata unmodified (IFMap tag bits pass through).
REQ-007 SHALL have at most one read outstanding per phase; with ready held high each word takes exactly 2 cycles.
REQ-008 SHALL compute addresses modulo 2^AW, wrapping from the maximum address to 0.
REQ-009 SHALL order phases filter then IFMap, never overlapping, and enter START the cycle after the last write.
REQ-010 SHALL assert Start for exactly one cycle, in the first START cycle with pe_ready=1, then enter RUN; with ready signals high, Start occurs at T+1+2*(filter_len+ifmap_len).
REQ-011 SHALL, in RUN, on pe_done=1 assert job_done for one cycle and return to IDLE the next cycle; pe_done outside RUN SHALL be ignored.
REQ-012 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-013 SHALL, on rst=0 at any time including mid-job, immediately enter IDLE and clear all ren, wen, Start, job_done, busy, addresses, data and configuration outputs to 0; any in-flight read SHALL be discarded.
REQ-014 SHALL assert job_ready=1 in the first cycle after reset release.

Structure
REQ-015 SHALL take the FSM state encoding, the mode encodings and the IFMap tag constants (2'b10 row start, 2'b01 row end) from shared package pe_sched_pkg.
REQ-016 SHALL contain one sub-module, pe_stream_loader, parameterized by data and address width, instantiated once for filter and once for IFMap.

Verification
REQ-017 Filter len 3 @0, IFMap len 12 @4, all ready high, accept at T -> Start only at T+31; FIFO contents equal source words in order with tags intact.
REQ-018 ready_Filter low for 5 cycles mid-phase -> no filter_ren while low; no word lost or duplicated; Start delayed 5 cycles.
REQ-019 filter_base=30, len 4, FILTER_MEM_AW=5 -> addresses 30, 31, 0, 1.
REQ-020 Both lens 0 -> START at T+1; pe_ready low 3 cycles -> Start at T+4, one cycle wide.
REQ-021 rst low during LOAD_IFMAP -> all outputs 0 asynchronously; job_ready=1 after release; next job completes normally.
REQ-022 pe_done pulsed during LOAD_FILTER is ignored; the RUN-state pe_done yields job_done one cycle wide and job_ready the next cycle.

Source files
------------

// File: rtl/pe_sched_pkg.sv
// Shared encodings for the PE job scheduler: FSM states, PE mode codes and
// the row tags carried in the two MSBs of each IFMap word.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StLoadFilter = 3'd1,
    StLoadIfmap  = 3'd2,
    StStart      = 3'd3,
    StRun        = 3'd4
  } sched_state_e;

  localparam logic [1:0] ModeConv      = 2'd0;
  localparam logic [1:0] ModeDepthwise = 2'd1;
  localparam logic [1:0] ModePointwise = 2'd2;
  localparam logic [1:0] ModeFc        = 2'd3;

  localparam logic [1:0] TagNone     = 2'b00;
  localparam logic [1:0] TagRowStart = 2'b10;
  localparam logic [1:0] TagRowEnd   = 2'b01;

endpackage

// File: rtl/pe_job_scheduler_if.sv
// Job descriptor, source-memory, FIFO and PE control signals of the scheduler.
// slave is the scheduler's view; master is the surrounding system's view.
interface pe_job_scheduler_if #(
  parameter int unsigned DATA_WIDTH        = 20,
  parameter int unsigned STRIDE_WIDTH      = 2,
  parameter int unsigned FILTER_SIZE_WIDTH = 4,
  parameter int unsigned IFMAP_MEM_AW      = 6,
  parameter int unsigned FILTER_MEM_AW     = 5
);
  logic                         job_valid;
  logic                         job_ready;
  logic [IFMAP_MEM_AW-1:0]      job_ifmap_base;
  logic [IFMAP_MEM_AW-1:0]      job_ifmap_len;
  logic [FILTER_MEM_AW-1:0]     job_filter_base;
  logic [FILTER_MEM_AW-1:0]     job_filter_len;
  logic [STRIDE_WIDTH-1:0]      job_stride;
  logic [FILTER_SIZE_WIDTH-1:0] job_filter_size;
  logic [1:0]                   job_mode;
  logic                         job_wr_psum;

  logic                         ifmap_ren;
  logic [IFMAP_MEM_AW-1:0]      ifmap_raddr;
  logic [DATA_WIDTH+1:0]        ifmap_rdata;
  logic                         filter_ren;
  logic [FILTER_MEM_AW-1:0]     filter_raddr;
  logic [DATA_WIDTH-1:0]        filter_rdata;

  logic                         wen_IFMap;
  logic [DATA_WIDTH+1:0]        IFMap_din;
  logic                         ready_IFMap;
  logic                         wen_Filter;
  logic [DATA_WIDTH-1:0]        Filter_din;
  logic                         ready_Filter;

  logic                         Start;
  logic [STRIDE_WIDTH-1:0]      stride;
  logic [FILTER_SIZE_WIDTH-1:0] filter_size;
  logic [1:0]                   mode;
  logic                         wr_psum;
  logic                         pe_ready;
  logic                         pe_done;
  logic                         busy;
  logic                         job_done;

  modport slave (
    input  job_valid, job_ifmap_base, job_ifmap_len, job_filter_base, job_filter_len,
    input  job_stride, job_filter_size, job_mode, job_wr_psum,
    input  ifmap_rdata, filter_rdata, ready_IFMap, ready_Filter, pe_ready, pe_done,
    output job_ready, ifmap_ren, ifmap_raddr, filter_ren, filter_raddr,
    output wen_IFMap, IFMap_din, wen_Filter, Filter_din,
    output Start, stride, filter_size, mode, wr_psum, busy, job_done
  );

  modport master (
    output job_valid, job_ifmap_base, job_ifmap_len, job_filter_base, job_filter_len,
    output job_stride, job_filter_size, job_mode, job_wr_psum,
    output ifmap_rdata, filter_rdata, ready_IFMap, ready_Filter, pe_ready, pe_done,
    input  job_ready, ifmap_ren, ifmap_raddr, filter_ren, filter_raddr,
    input  wen_IFMap, IFMap_din, wen_Filter, Filter_din,
    input  Start, stride, filter_size, mode, wr_psum, busy, job_done
  );
endinterface

// File: rtl/pe_stream_loader.sv
// Copies len words from a 1-cycle-latency source memory into a FIFO, one
// word per read/write sub-cycle pair, with at most one read outstanding.
module pe_stream_loader #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  fifo_ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  last
);
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  pend_q, pend_d;

  always_comb begin
    idx_d  = idx_q;
    pend_d = pend_q;
    ren    = 1'b0;
    raddr  = '0;
    wen    = 1'b0;
    din    = '0;
    last   = 1'b0;
    if (!en) begin
      idx_d  = '0;
      pend_d = 1'b0;
    end else if (pend_q) begin
      wen    = 1'b1;
      din    = rdata;
      pend_d = 1'b0;
      if (idx_q == len - ADDR_WIDTH'(1)) begin
        last  = 1'b1;
        idx_d = '0;
      end else begin
        idx_d = idx_q + ADDR_WIDTH'(1);
      end
    end else if (fifo_ready) begin
      ren    = 1'b1;
      // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
      raddr  = base + idx_q;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/pe_job_scheduler.sv
// Accepts a job descriptor, streams filter then IFMap words into the PE FIFOs,
// pulses Start once the PE is ready and reports completion on pe_done.
module pe_job_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 20,
  parameter int unsigned STRIDE_WIDTH      = 2,
  parameter int unsigned FILTER_SIZE_WIDTH = 4,
  parameter int unsigned IFMAP_MEM_AW      = 6,
  parameter int unsigned FILTER_MEM_AW     = 5
) (
  input logic               clk,
  input logic               rst,
  pe_job_scheduler_if.slave bus
);
  sched_state_e state_q, state_d;

  logic [IFMAP_MEM_AW-1:0]      ifmap_base_q, ifmap_len_q;
  logic [FILTER_MEM_AW-1:0]     filter_base_q, filter_len_q;
  logic [STRIDE_WIDTH-1:0]      stride_q;
  logic [FILTER_SIZE_WIDTH-1:0] filter_size_q;
  logic [1:0]                   mode_q;
  logic                         wr_psum_q;
  logic                         accept, filter_last, ifmap_last;

  assign accept = bus.job_valid && (state_q == StIdle);

  always_comb begin
    state_d       = state_q;
    bus.job_ready = 1'b0;
    bus.Start     = 1'b0;
    bus.job_done  = 1'b0;
    bus.busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        bus.job_ready = 1'b1;
        // Zero-length phases are skipped directly from the accept cycle.
        if (accept) begin
          if (bus.job_filter_len != '0)     state_d = StLoadFilter;
          else if (bus.job_ifmap_len != '0) state_d = StLoadIfmap;
          else                              state_d = StStart;
        end
      end
      StLoadFilter: begin
        if (filter_last) state_d = (ifmap_len_q != '0) ? StLoadIfmap : StStart;
      end
      StLoadIfmap: begin
        if (ifmap_last) state_d = StStart;
      end
      StStart: begin
        if (bus.pe_ready) begin
          bus.Start = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (bus.pe_done) begin
          bus.job_done = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      ifmap_base_q  <= '0;
      ifmap_len_q   <= '0;
      filter_base_q <= '0;
      filter_len_q  <= '0;
      stride_q      <= '0;
      filter_size_q <= '0;
      mode_q        <= '0;
      wr_psum_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ifmap_base_q  <= bus.job_ifmap_base;
        ifmap_len_q   <= bus.job_ifmap_len;
        filter_base_q <= bus.job_filter_base;
        filter_len_q  <= bus.job_filter_len;
        stride_q      <= bus.job_stride;
        filter_size_q <= bus.job_filter_size;
        mode_q        <= bus.job_mode;
        wr_psum_q     <= bus.job_wr_psum;
      end
    end
  end

  assign bus.stride      = stride_q;
  assign bus.filter_size = filter_size_q;
  assign bus.mode        = mode_q;
  assign bus.wr_psum     = wr_psum_q;

  pe_stream_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(FILTER_MEM_AW)
  ) u_filter_loader (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == StLoadFilter),
    .base      (filter_base_q),
    .len       (filter_len_q),
    .fifo_ready(bus.ready_Filter),
    .rdata     (bus.filter_rdata),
    .ren       (bus.filter_ren),
    .raddr     (bus.filter_raddr),
    .wen       (bus.wen_Filter),
    .din       (bus.Filter_din),
    .last      (filter_last)
  );

  pe_stream_loader #(
    .DATA_WIDTH(DATA_WIDTH + 2),
    .ADDR_WIDTH(IFMAP_MEM_AW)
  ) u_ifmap_loader (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == StLoadIfmap),
    .base      (ifmap_base_q),
    .len       (ifmap_len_q),
    .fifo_ready(bus.ready_IFMap),
    .rdata     (bus.ifmap_rdata),
    .ren       (bus.ifmap_ren),
    .raddr     (bus.ifmap_raddr),
    .wen       (bus.wen_IFMap),
    .din       (bus.IFMap_din),
    .last      (ifmap_last)
  );

endmodule
